demux_router: RTL

DEMUX_ROUTER -- requirements
Module: demux_router

---
 rtl/demux_router_if.sv | 26 ++
 rtl/demux_router.sv | 55 +++++
 2 files changed

// File: rtl/demux_router_if.sv
// demux_router_if: upstream word channel plus NOUT downstream ready/valid channels
//   in_valid/in_sel/in_data  word offered upstream, tagged with its destination channel
//   in_ready                 router can take the offered word this cycle
//   out_valid/out_data       per-channel held word; channel k at out_data[k*DATA_W +: DATA_W]
//   out_ready                per-channel downstream ready
//   master: upstream source and downstream sinks; slave: the router
interface demux_router_if #(
   parameter int DATA_W = 8,
   parameter int NOUT = 4
);
   logic in_valid;
   logic [1:0] in_sel;
   logic [DATA_W-1:0] in_data;
   logic in_ready;
   logic [NOUT-1:0] out_valid;
   logic [NOUT*DATA_W-1:0] out_data;
   logic [NOUT-1:0] out_ready;
   modport master (
      output in_valid, in_sel, in_data, out_ready,
      input in_ready, out_valid, out_data
   );
   modport slave (
      input in_valid, in_sel, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/demux_router.sv
// demux_router: routes each accepted word into a one-entry register of channel in_sel
//   clk       rising-edge clock
//   rst       synchronous active-high reset; empties every channel and zeroes its data
//   bus       demux_router_if slave modport (upstream word in, per-channel words out)
//   stat_cnt  with DEMUX_ROUTER_STATS_EN defined: per-channel 16-bit count of output
//             handshakes, channel k at stat_cnt[k*16 +: 16], wrapping at 16'hFFFF
module demux_router #(
   parameter int DATA_W = 8,
   parameter int NOUT = 4
) (
   input logic clk,
   input logic rst,
   demux_router_if.slave bus
`ifdef DEMUX_ROUTER_STATS_EN
   , output logic [NOUT*16-1:0] stat_cnt
`endif
);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t st [NOUT];
   state_t st_nxt [NOUT];
   logic [NOUT-1:0] acc;
   logic [NOUT-1:0] drain;
   logic [DATA_W-1:0] data [NOUT];
   always_comb begin
      // only the addressed channel decides readiness, so a stalled channel never blocks others;
      // a full channel whose word drains this cycle can take the next word in the same cycle
      bus.in_ready = !rst && (st[bus.in_sel] == EMPTY || bus.out_ready[bus.in_sel]);
      for (int i = 0; i < NOUT; i++) begin
         acc[i] = bus.in_valid && bus.in_ready && int'(bus.in_sel) == i;
         drain[i] = st[i] == FULL && bus.out_ready[i];
         st_nxt[i] = acc[i] ? FULL : drain[i] ? EMPTY : st[i];
         bus.out_valid[i] = st[i] == FULL;
         bus.out_data[i*DATA_W +: DATA_W] = data[i];
      end
   end
   always_ff @(posedge clk) begin
      for (int i = 0; i < NOUT; i++) begin
         if (rst) begin
            st[i] <= EMPTY;
            data[i] <= '0;
         end else begin
            st[i] <= st_nxt[i];
            if (acc[i]) data[i] <= bus.in_data;
         end
      end
   end
`ifdef DEMUX_ROUTER_STATS_EN
   always_ff @(posedge clk) begin
      for (int i = 0; i < NOUT; i++) begin
         if (rst) stat_cnt[i*16 +: 16] <= '0;
         else if (drain[i]) stat_cnt[i*16 +: 16] <= stat_cnt[i*16 +: 16] + 16'd1;
      end
   end
`endif
endmodule
